temp_input: RTL and testbench
=============================

Name: temp_input

Overview:
- Digit-serial entry block for a 3-digit BCD temperature set-point (000-999) driven by a 4-bit digit input and an enter pushbutton.
- The operator keys digits in the order ones, tens, hundreds, then presses enter once more to commit.
- The block exposes the digit being entered, the new value under construction, and the previously committed value, for display logic downstream.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on the enter input (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- enter  input  1  asynchronous pushbutton, active-high, already debounced upstream.
- value  input  4  digit presented by the operator (switches).
- input_state  output  2  entry FSM state: 0 = ONES, 1 = TENS, 2 = HUNS, 3 = DONE.
- current_value  output  4  registered copy of value, sampled every clock.
- temp_value_ones  output  4  working value, ones digit (BCD).
- temp_value_tens  output  4  working value, tens digit (BCD).
- temp_value_huns  output  4  working value, hundreds digit (BCD).
- temp_value_ones_old  output  4  previously committed value, ones digit.
- temp_value_tens_old  output  4  previously committed value, tens digit.
- temp_value_huns_old  output  4  previously committed value, hundreds digit.

Behaviour:
- Reset (rst low, asynchronous):
  - input_state = 0 (ONES).
  - All temp_value_* and temp_value_*_old = 0.
  - current_value = 0.
  - Synchronizer flops cleared.
  - Reset mid-entry discards partial and committed values.
- Release: synchronous in effect; first action possible on the clock after rst goes high.
- current_value <= value every clock (1-cycle latency), independent of FSM state.
- Enter handling:
  - enter passes through SYNC_STAGES flops plus one history flop.
  - Event = synchronized high AND history low (rising edge).
  - One event per press regardless of hold length.
  - Latency from first clock sampling enter high to register update = SYNC_STAGES+1 clocks.
  - Presses must be high ≥2 clocks and low ≥2 clocks between presses to be guaranteed seen.
- Digit validity: the digit is the registered current_value at the event. Digits 0xA-0xF are invalid.
- On an event with an invalid digit in ONES/TENS/HUNS: no register change, no state change.
- FSM on each valid event:
  - ONES: temp_value_ones <= digit, go to TENS.
  - TENS: temp_value_tens <= digit, go to HUNS.
  - HUNS: temp_value_huns <= digit, go to DONE.
  - DONE (digit value ignored, any value accepted):
    - temp_value_*_old <= temp_value_* (all three).
    - temp_value_* <= 0.
    - Go to ONES.
- No events: all registers hold.
- Working digits not yet entered for the current number remain 0 (cleared on commit/reset).
- Old value changes only on a DONE commit or reset.
- input_state encoding is exactly as above; no other states reachable. Any illegal encoding recovers to ONES on the next clock.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: all outputs 0, input_state 0. Toggle value to 7 -> current_value 7 one clock later, nothing else changes.
- Enter digits 3, 2, 1 (one press each):
  - input_state steps 0 -> 1 -> 2 -> 3.
  - huns/tens/ones = 1/2/3; old = 000.
  - Press enter again -> old = 123, current = 000, state 0.
- Continue with digits 5, 5, 5:
  - cur = 555, old = 123, state 3.
  - Commit -> old 555.
  - Then digits 1, 0, 0 -> cur 001, old 555.
  - Commit -> old 001.
  - Then 4, 4, 4 -> cur 444, old 001.
- Invalid digit: in ONES, value = 0xB, press -> state stays 0, ones stays 0. Then value = 9, press -> ones 9, state 1.
- Enter held high 20 clocks -> exactly one state advance. Second press after ≥2 low clocks -> one more advance.
- Reset asserted in HUNS with old = 555, cur tens/ones = 2/3 -> all outputs 0 and state 0 immediately (asynchronous, no clock needed).

Source files
------------

// File: rtl/temp_input.sv
// Digit-serial BCD set-point entry: ones, tens, hundreds, then enter to commit.
// The enter pushbutton is synchronized and edge-detected; digits come from a registered copy of value.
module temp_input #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic [3:0] value,
  output logic [1:0] input_state,
  output logic [3:0] current_value,
  output logic [3:0] temp_value_ones,
  output logic [3:0] temp_value_tens,
  output logic [3:0] temp_value_huns,
  output logic [3:0] temp_value_ones_old,
  output logic [3:0] temp_value_tens_old,
  output logic [3:0] temp_value_huns_old
);

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned SYNC_W    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(9);

  typedef enum logic [1:0] {
    ONES = 2'd0,
    TENS = 2'd1,
    HUNS = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SYNC_W-1:0]    r_sync;
  logic                 r_hist;
  logic [DIGIT_W-1:0]   r_cur;
  logic [DIGIT_W-1:0]   r_ones;
  logic [DIGIT_W-1:0]   r_tens;
  logic [DIGIT_W-1:0]   r_huns;
  logic [DIGIT_W-1:0]   r_ones_old;
  logic [DIGIT_W-1:0]   r_tens_old;
  logic [DIGIT_W-1:0]   r_huns_old;
  logic [DIGIT_W-1:0]   w_ones_nxt;
  logic [DIGIT_W-1:0]   w_tens_nxt;
  logic [DIGIT_W-1:0]   w_huns_nxt;
  logic [DIGIT_W-1:0]   w_ones_old_nxt;
  logic [DIGIT_W-1:0]   w_tens_old_nxt;
  logic [DIGIT_W-1:0]   w_huns_old_nxt;
  logic                 w_evt;
  logic                 w_valid;

  // Enter synchronizer, history flop and registered digit sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_cur  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_W-2:0], enter};
      r_hist <= r_sync[SYNC_W-1];
      r_cur  <= value;
    end
  end

  // One event per press: synchronized level high while history still low
  assign w_evt   = r_sync[SYNC_W-1] & ~r_hist;
  assign w_valid = (r_cur <= MAX_DIGIT);

  // State and digit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ONES;
      r_ones     <= '0;
      r_tens     <= '0;
      r_huns     <= '0;
      r_ones_old <= '0;
      r_tens_old <= '0;
      r_huns_old <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ones     <= w_ones_nxt;
      r_tens     <= w_tens_nxt;
      r_huns     <= w_huns_nxt;
      r_ones_old <= w_ones_old_nxt;
      r_tens_old <= w_tens_old_nxt;
      r_huns_old <= w_huns_old_nxt;
    end
  end

  // Next-state and datapath update on each enter event
  always_comb begin
    w_state_nxt    = r_state;
    w_ones_nxt     = r_ones;
    w_tens_nxt     = r_tens;
    w_huns_nxt     = r_huns;
    w_ones_old_nxt = r_ones_old;
    w_tens_old_nxt = r_tens_old;
    w_huns_old_nxt = r_huns_old;
    case (r_state)
      ONES: begin
        if (w_evt && w_valid) begin
          w_ones_nxt  = r_cur;
          w_state_nxt = TENS;
        end
      end
      TENS: begin
        if (w_evt && w_valid) begin
          w_tens_nxt  = r_cur;
          w_state_nxt = HUNS;
        end
      end
      HUNS: begin
        if (w_evt && w_valid) begin
          w_huns_nxt  = r_cur;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Commit ignores the digit on the switches
        if (w_evt) begin
          w_ones_old_nxt = r_ones;
          w_tens_old_nxt = r_tens;
          w_huns_old_nxt = r_huns;
          w_ones_nxt     = '0;
          w_tens_nxt     = '0;
          w_huns_nxt     = '0;
          w_state_nxt    = ONES;
        end
      end
      default: w_state_nxt = ONES;
    endcase
  end

  assign input_state         = r_state;
  assign current_value       = r_cur;
  assign temp_value_ones     = r_ones;
  assign temp_value_tens     = r_tens;
  assign temp_value_huns     = r_huns;
  assign temp_value_ones_old = r_ones_old;
  assign temp_value_tens_old = r_tens_old;
  assign temp_value_huns_old = r_huns_old;

endmodule

// File: tb/tb_temp_input.sv
// Directed bench for temp_input: expected snapshots are queued per press and checked after it settles.
module tb_temp_input;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [3:0] value;
  logic [1:0] input_state;
  logic [3:0] current_value;
  logic [3:0] t_ones, t_tens, t_huns;
  logic [3:0] o_ones, o_tens, o_huns;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [1:0] st;
    logic [3:0] ones, tens, huns;
    logic [3:0] oones, otens, ohuns;
  } snap_t;

  snap_t model;
  snap_t sb_q[$];

  temp_input #(.SYNC_STAGES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enter               (enter),
    .value               (value),
    .input_state         (input_state),
    .current_value       (current_value),
    .temp_value_ones     (t_ones),
    .temp_value_tens     (t_tens),
    .temp_value_huns     (t_huns),
    .temp_value_ones_old (o_ones),
    .temp_value_tens_old (o_tens),
    .temp_value_huns_old (o_huns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input snap_t e);
    chk({tag, ".state"},    4'(input_state), 4'(e.st));
    chk({tag, ".ones"},     t_ones, e.ones);
    chk({tag, ".tens"},     t_tens, e.tens);
    chk({tag, ".huns"},     t_huns, e.huns);
    chk({tag, ".ones_old"}, o_ones, e.oones);
    chk({tag, ".tens_old"}, o_tens, e.otens);
    chk({tag, ".huns_old"}, o_huns, e.ohuns);
  endtask

  // Reference behaviour of one press with digit d
  task automatic model_press(input logic [3:0] d);
    logic ok;
    ok = (d <= 4'd9);
    case (model.st)
      2'd0: if (ok) begin model.ones = d; model.st = 2'd1; end
      2'd1: if (ok) begin model.tens = d; model.st = 2'd2; end
      2'd2: if (ok) begin model.huns = d; model.st = 2'd3; end
      default: begin
        model.oones = model.ones; model.otens = model.tens; model.ohuns = model.huns;
        model.ones = 4'd0; model.tens = 4'd0; model.huns = 4'd0;
        model.st = 2'd0;
      end
    endcase
  endtask

  // Press with digit d held for 'hold' clocks; expectation queued, then popped after settling
  task automatic press(input string tag, input logic [3:0] d, input int hold);
    snap_t e;
    value = d;
    tick(2);
    model_press(d);
    sb_q.push_back(model);
    enter = 1'b1;
    tick(hold);
    enter = 1'b0;
    tick(5);
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_snap(tag, e);
    end
  endtask

  task automatic model_reset();
    model.st = 2'd0;
    model.ones = 4'd0; model.tens = 4'd0; model.huns = 4'd0;
    model.oones = 4'd0; model.otens = 4'd0; model.ohuns = 4'd0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    enter  = 1'b0;
    value  = 4'd0;
    rst    = 1'b0;
    model_reset();
    #12;
    chk_snap("reset", model);
    chk("reset.cur", current_value, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);

    // Idle: value change shows on current_value one clock later only
    value = 4'd7;
    chk("idle.cur_before", current_value, 4'd0);
    tick(1);
    chk("idle.cur", current_value, 4'd7);
    chk_snap("idle", model);

    press("d3", 4'd3, 2);
    press("d2", 4'd2, 2);
    press("d1", 4'd1, 2);
    press("commit123", 4'd0, 2);
    chk("commit123.huns_old", o_huns, 4'd1);

    press("d5a", 4'd5, 2);
    press("d5b", 4'd5, 2);
    press("d5c", 4'd5, 2);
    press("commit555", 4'hF, 2);
    press("d1b", 4'd1, 2);
    press("d0a", 4'd0, 2);
    press("d0b", 4'd0, 2);
    press("commit001", 4'd0, 2);
    press("d4a", 4'd4, 2);
    press("d4b", 4'd4, 3);
    press("d4c", 4'd4, 2);
    press("commit444", 4'd0, 2);

    // Invalid digit is ignored, valid digit then accepted
    press("invalidB", 4'hB, 2);
    press("valid9", 4'd9, 2);

    // Long hold gives exactly one advance; next press gives one more
    press("hold20", 4'd8, 20);
    press("after_hold", 4'd6, 2);
    press("commit689", 4'd0, 2);

    // Async reset while in HUNS with committed 555
    press("r5a", 4'd5, 2);
    press("r5b", 4'd5, 2);
    press("r5c", 4'd5, 2);
    press("rcommit", 4'd0, 2);
    press("r3", 4'd3, 2);
    press("r2", 4'd2, 2);
    chk("pre_rst.state", 4'(input_state), 4'd2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk_snap("async_rst", model);
    chk("async_rst.cur", current_value, 4'd0);
    #2;
    rst = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
